// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/done handshake bundle for the sequential restoring divider.
//   start       : request, taken when the divider is not busy
//   dividend    : unsigned numerator, sampled on the accepting edge
//   divisor     : unsigned denominator, sampled on the accepting edge
//   busy        : an operation is in progress
//   done        : one-cycle completion pulse; results valid from here on
//   quotient    : unsigned quotient (all ones on divide-by-zero)
//   remainder   : unsigned remainder (dividend on divide-by-zero)
//   div_by_zero : the last accepted divisor was zero
// Modports: master = requester, slave = divider.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential restoring divider, one quotient bit per clock.
// An accepted request takes WIDTH clocks; a zero divisor completes on the
// accepting edge with quotient = all ones, remainder = dividend.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if slave modport (start/operands in, status/results out)
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    // Partial remainder A. After every restoring step A < D, so the top bit of
    // the (WIDTH+1)-bit remainder is always zero and only the trial
    // subtraction needs the extra bit.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_accept;
    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_q_next;

    // Start is only looked at when no operation is running.
    assign w_accept = bus.start && (r_state != S_RUN);

    // One restoring iteration on {A,Q} shifted left by one.
    always_comb begin
        w_a_shift = {r_a, r_q[WIDTH-1]};
        w_trial   = w_a_shift - {1'b0, r_d};
        w_fits    = ~w_trial[WIDTH];
        w_a_next  = w_fits ? w_trial[WIDTH-1:0] : w_a_shift[WIDTH-1:0];
        w_q_next  = {r_q[WIDTH-2:0], w_fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_q_next;
                        r_rem   <= w_a_next;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                    if (w_accept) begin
                        r_q   <= bus.dividend;
                        r_d   <= bus.divisor;
                        r_a   <= '0;
                        r_dbz <= 1'b0;
                        if (bus.divisor != '0) begin
                            r_state <= S_RUN;
                            r_count <= CW'(WIDTH);
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero divisor: result is ready immediately.
                            r_state <= S_DONE;
                            r_count <= '0;
                            r_done  <= 1'b1;
                            r_dbz   <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= bus.dividend;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's array multiplier.
- Accepts an unsigned dividend and divisor through a start/done handshake.
- Computes one quotient bit per clock and returns the quotient and remainder after WIDTH cycles.
- Used next to the multiplier in the arithmetic test designs on the FPGA starter board.

Parameters:
WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder (minimum 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  reset, asynchronous and active-low
start  input  1  request; sampled only when not busy
dividend  input  WIDTH  unsigned numerator, captured when start is accepted
divisor  input  WIDTH  unsigned denominator, captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result outputs valid from this cycle onward
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  high with done when the captured divisor was 0; held until next accept

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0; internal registers and counter cleared.
  - Reset during RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- Accept: start=1 at a rising edge E0 while state is IDLE or DONE.
  - Capture dividend into shift register Q and divisor into D.
  - Clear partial remainder A (WIDTH+1 bits) and clear div_by_zero.
  - If divisor≠0: state→RUN, count=WIDTH, busy=1 from E0.
  - If divisor=0: state→DONE directly at E0.
    - quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1, done=1 after E0.
- RUN, each edge performs one restoring iteration:
  - {A,Q} shifted left 1.
  - T = A − {1'b0,D}.
  - If T ≥ 0 (MSB clear): A=T, Q[0]=1. Else: A unchanged, Q[0]=0.
  - count decrements.
  - On the edge where count reaches 0 (edge E_WIDTH):
    - state→DONE, quotient=Q, remainder=A[WIDTH-1:0].
    - busy=0, done=1.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH cycles after the accept edge (1 cycle for divide-by-zero).
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE with done=0, unless start=1, which is a new accept (back-to-back).
  - quotient, remainder and div_by_zero hold their values until the next accept or reset; they do not change during the following operation's RUN.
- start during RUN is ignored; operand inputs may change freely after acceptance.
- busy and done are never high simultaneously.
- Arithmetic invariant: dividend = quotient*divisor + remainder, with remainder < divisor (divisor≠0).
- Full range: dividend=0 gives quotient=0, remainder=0; divisor > dividend gives quotient=0, remainder=dividend.

Test Plan:
- WIDTH=8, 100/7 -> busy for 8 cycles, done pulse 8 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
- 255/1 then back-to-back start in the DONE cycle with 200/16 -> first result 255/0, second 12/8, with no IDLE cycle between.
- 5/9 and 0/3 -> quotient=0, remainder=5; then quotient=0, remainder=0.
- 42/0 -> done one cycle after accept, quotient=255, remainder=42, div_by_zero=1; the next valid operation clears div_by_zero.
- Start 100/7, pulse start with 9/3 at cycle 3 of RUN, change operands mid-run -> second start ignored, result still 14/2, single done pulse.
- Start 200/3, drop rst_n for 1 cycle at cycle 4 -> all outputs 0 immediately, no done; a fresh 200/3 afterwards gives 66/2.
- Randomised sweep of ~1000 operand pairs against the arithmetic invariant as a closing check.
